// File: rtl/uart_bus_slave.sv
// Memory-mapped 8N1 UART slave: STATUS/DATA registers on the system bus,
// one TX and one RX bit engine, sticky completion/error flags driven as IRQs.
`ifndef WORD_ADDR_BUS
`define WORD_ADDR_BUS 29:0
`endif
`ifndef WORD_DATA_BUS
`define WORD_DATA_BUS 31:0
`endif

module uart_bus_slave #(
    parameter int CLK_DIV = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS_,
    input  logic                  As_,
    input  logic                  RW,
    input  logic [`WORD_ADDR_BUS] Addr,
    input  logic [`WORD_DATA_BUS] WrData,
    output logic [`WORD_DATA_BUS] RdData,
    output logic                  Rdy_,
    input  logic                  UartRX,
    output logic                  UartTX,
    output logic                  IrqRx,
    output logic                  IrqTx
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic access, wr_status, wr_data;
    assign access    = ~CS_ & ~As_;
    assign wr_status = access & RW & ~Addr[0];
    assign wr_data   = access & RW & Addr[0];

    logic unused_bits;
    assign unused_bits = ^{Addr[$high(Addr):1], WrData[$high(WrData):8]};

    // ---------------- TX engine ----------------
    state_t           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             uart_tx_q, uart_tx_d;
    logic             tx_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_state_q <= S_IDLE;
        else       tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            S_IDLE:  if (wr_data) tx_state_d = S_START;
            S_START: if (tx_cnt_q == CNT_LAST) tx_state_d = S_DATA;
            S_DATA:  if (tx_cnt_q == CNT_LAST && tx_idx_q == 3'd7) tx_state_d = S_STOP;
            S_STOP:  if (tx_cnt_q == CNT_LAST) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_cnt_d   = '0;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        if (tx_state_q == S_IDLE) begin
            tx_idx_d = 3'd0;
            if (wr_data) tx_shift_d = WrData[7:0];
        end else if (tx_cnt_q != CNT_LAST) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else if (tx_state_q == S_DATA) begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
    end

    // Line level is registered from the next state so it changes on the same edge as the FSM.
    always_comb begin
        uart_tx_d = 1'b1;
        case (tx_state_d)
            S_START: uart_tx_d = 1'b0;
            S_DATA:  uart_tx_d = tx_shift_d[0];
            default: uart_tx_d = 1'b1;
        endcase
    end
    assign tx_end = (tx_state_q == S_STOP) && (tx_cnt_q == CNT_LAST);

    // ---------------- RX engine ----------------
    logic             sync1_q, sync2_q;
    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_stop_smp, rx_ok, rx_ferr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state_q <= S_IDLE;
        else       rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_IDLE:  if (!sync2_q) rx_state_d = S_START;
            S_START: if (rx_cnt_q == CNT_HALF) rx_state_d = sync2_q ? S_IDLE : S_DATA;
            S_DATA:  if (rx_cnt_q == CNT_LAST && rx_idx_q == 3'd7) rx_state_d = S_STOP;
            S_STOP:  if (rx_cnt_q == CNT_LAST) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_d   = '0;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            S_IDLE:  rx_idx_d = 3'd0;
            S_START: if (rx_cnt_q != CNT_HALF) rx_cnt_d = rx_cnt_q + 1'b1;
            default: begin
                if (rx_cnt_q != CNT_LAST) begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end else if (rx_state_q == S_DATA) begin
                    rx_idx_d   = rx_idx_q + 3'd1;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                end
            end
        endcase
    end

    always_comb begin
        rx_stop_smp = (rx_state_q == S_STOP) && (rx_cnt_q == CNT_LAST);
        rx_ok       = rx_stop_smp & sync2_q;
        rx_ferr     = rx_stop_smp & ~sync2_q;
        rx_data_d   = rx_ok ? rx_shift_q : rx_data_q;
    end

    // ---------------- Flags and bus ----------------
    logic        rx_done_q, rx_done_d, tx_done_q, tx_done_d, ferr_q, ferr_d;
    logic        rdy_n_q, rdy_n_d;
    logic [31:0] rd_data_q, rd_data_d, status;

    // Hardware set takes priority over a software clear in the same cycle.
    always_comb begin
        rx_done_d = rx_ok   | (rx_done_q & ~(wr_status & WrData[0]));
        tx_done_d = tx_end  | (tx_done_q & ~(wr_status & WrData[1]));
        ferr_d    = rx_ferr | (ferr_q    & ~(wr_status & WrData[4]));
        status    = {27'd0, ferr_q, (tx_state_q != S_IDLE), (rx_state_q != S_IDLE),
                     tx_done_q, rx_done_q};
        rdy_n_d   = ~access;
        rd_data_d = '0;
        if (access && !RW) rd_data_d = Addr[0] ? {24'd0, rx_data_q} : status;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_q  <= 1'b1;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            ferr_q     <= 1'b0;
            rdy_n_q    <= 1'b1;
            rd_data_q  <= '0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            uart_tx_q  <= uart_tx_d;
            sync1_q    <= UartRX;
            sync2_q    <= sync1_q;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            tx_done_q  <= tx_done_d;
            ferr_q     <= ferr_d;
            rdy_n_q    <= rdy_n_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign UartTX = uart_tx_q;
    assign Rdy_   = rdy_n_q;
    assign RdData = rd_data_q;
    assign IrqRx  = rx_done_q;
    assign IrqTx  = tx_done_q;
endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed bench for uart_bus_slave at CLK_DIV=4: register vectors from a table,
// then hand-timed TX, RX, collision and reset sequences.
module tb_uart_bus_slave;
    logic        clk = 1'b0;
    logic        reset, CS_, As_, RW, UartRX;
    logic [29:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Rdy_, UartTX, IrqRx, IrqTx;

    int checks = 0;
    int errors = 0;

    uart_bus_slave #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .CS_(CS_), .As_(As_), .RW(RW), .Addr(Addr),
        .WrData(WrData), .RdData(RdData), .Rdy_(Rdy_), .UartRX(UartRX),
        .UartTX(UartTX), .IrqRx(IrqRx), .IrqTx(IrqTx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs_n;
        logic        as_n;
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        exp_rdy;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive mid-cycle, sample the registered response one cycle later.
    task automatic bus(input logic cs_n, input logic as_n, input logic rw,
                       input logic [29:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic rdy);
        @(negedge clk);
        CS_ = cs_n; As_ = as_n; RW = rw; Addr = a; WrData = wd;
        @(negedge clk);
        CS_ = 1'b1; As_ = 1'b1; RW = 1'b0;
        rd = RdData; rdy = Rdy_;
        $display("bus cs_=%0b as_=%0b rw=%0b addr=%0d wd=0x%0h -> rdy_=%0b rd=0x%0h",
                 cs_n, as_n, rw, a, wd, rdy, rd);
    endtask

    task automatic rd_reg(input string name, input logic [29:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic rdy;
        bus(1'b0, 1'b0, 1'b0, a, 32'd0, rd, rdy);
        chk({name, "_rdy"}, {31'd0, rdy}, 32'd0);
        chk(name, rd, exp);
    endtask

    task automatic wr_reg(input string name, input logic [29:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic rdy;
        bus(1'b0, 1'b0, 1'b1, a, wd, rd, rdy);
        chk({name, "_rdy"}, {31'd0, rdy}, 32'd0);
    endtask

    // Drives one frame at 4 cycles/bit; returns mid-cycle of the stop-bit centre sample.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        UartRX = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (4) @(negedge clk);
            UartRX = b[k];
        end
        repeat (4) @(negedge clk);
        UartRX = stop_bit;
        repeat (4) @(negedge clk);
        UartRX = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] rd;
        logic        rdy;
        logic [9:0]  a5_frame;
        logic [8:0]  frame11;

        reset = 1'b1; CS_ = 1'b1; As_ = 1'b1; RW = 1'b0;
        Addr = '0; WrData = '0; UartRX = 1'b1;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 30'd0, 32'd0,        1'b0, 32'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 30'd1, 32'd0,        1'b0, 32'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 30'd0, 32'd0,        1'b1, 32'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 30'd0, 32'd0,        1'b1, 32'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 30'd0, 32'hFFFFFFFF, 1'b0, 32'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 30'd1, 32'h55,       1'b1, 32'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 30'd2, 32'd0,        1'b0, 32'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 30'd3, 32'd0,        1'b0, 32'd0};

        repeat (3) @(negedge clk);
        chk("rst_uarttx", {31'd0, UartTX}, 32'd1);
        chk("rst_rdy", {31'd0, Rdy_}, 32'd1);
        chk("rst_rddata", RdData, 32'd0);
        chk("rst_irq", {30'd0, IrqRx, IrqTx}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus(vecs[i].cs_n, vecs[i].as_n, vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, rdy);
            chk($sformatf("vec%0d_rdy", i), {31'd0, rdy}, {31'd0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end
        // Non-selected DATA write in the table must not have started a frame.
        rd_reg("status_after_vecs", 30'd0, 32'd0);

        // TX frame 0xA5: start, LSB-first data, stop; each level held 4 cycles.
        a5_frame = 10'b1101001010;
        wr_reg("tx_a5_wr", 30'd1, 32'hA5);
        for (int j = 0; j < 40; j++) begin
            chk($sformatf("tx_a5_bit%0d_c%0d", j / 4, j % 4), {31'd0, UartTX},
                {31'd0, a5_frame[j / 4]});
            if (j == 39) chk("tx_a5_irq_early", {31'd0, IrqTx}, 32'd0);
            @(negedge clk);
        end
        chk("tx_a5_irq_w41", {31'd0, IrqTx}, 32'd1);
        rd_reg("tx_a5_status", 30'd0, 32'h2);
        wr_reg("tx_clr", 30'd0, 32'h2);
        chk("tx_clr_irq", {31'd0, IrqTx}, 32'd0);
        rd_reg("tx_clr_status", 30'd0, 32'h0);

        // Busy drop: 0x11 accepted in cycle N, 0x22 in N+2 is dropped.
        frame11 = {1'b1, 8'h11};
        wr_reg("drop_wr11", 30'd1, 32'h11);
        wr_reg("drop_wr22", 30'd1, 32'h22);
        rd_reg("drop_busy", 30'd0, 32'h8);
        for (int j = 0; j < 36; j++) begin
            chk($sformatf("drop_bit%0d_c%0d", j / 4, j % 4), {31'd0, UartTX},
                {31'd0, frame11[j / 4]});
            @(negedge clk);
        end
        chk("drop_irq", {31'd0, IrqTx}, 32'd1);
        wr_reg("drop_clr", 30'd0, 32'h2);

        // RX loopback of 0x3C.
        send_rx(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        chk("rx3c_irq", {31'd0, IrqRx}, 32'd1);
        rd_reg("rx3c_data", 30'd1, 32'h3C);
        rd_reg("rx3c_status", 30'd0, 32'h1);
        wr_reg("rx3c_clr", 30'd0, 32'h1);
        chk("rx3c_clr_irq", {31'd0, IrqRx}, 32'd0);

        // One-cycle glitch is a false start.
        @(negedge clk); UartRX = 1'b0;
        @(negedge clk); UartRX = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_irq", {31'd0, IrqRx}, 32'd0);
        rd_reg("glitch_status", 30'd0, 32'h0);

        // Stop bit 0: frame error, data register keeps 0x3C.
        send_rx(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        rd_reg("ferr_status", 30'd0, 32'h10);
        rd_reg("ferr_data", 30'd1, 32'h3C);
        wr_reg("ferr_clr", 30'd0, 32'h10);
        rd_reg("ferr_clr_status", 30'd0, 32'h0);

        // Clear of rx_done in the very cycle it sets: set wins.
        send_rx(8'h96, 1'b1);
        CS_ = 1'b0; As_ = 1'b0; RW = 1'b1; Addr = 30'd0; WrData = 32'h1;
        @(negedge clk);
        CS_ = 1'b1; As_ = 1'b1; RW = 1'b0;
        chk("coll_rdy", {31'd0, Rdy_}, 32'd0);
        chk("coll_irq", {31'd0, IrqRx}, 32'd1);
        rd_reg("coll_status", 30'd0, 32'h1);
        rd_reg("coll_data", 30'd1, 32'h96);

        // Asynchronous reset mid-frame during a pending DATA read.
        wr_reg("rst_tx_wr", 30'd1, 32'h00);
        repeat (6) @(negedge clk);
        chk("rst_pre_tx", {31'd0, UartTX}, 32'd0);
        CS_ = 1'b0; As_ = 1'b0; RW = 1'b0; Addr = 30'd1;
        @(posedge clk);
        #2;
        chk("rst_pre_rd", RdData, 32'h96);
        reset = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, UartTX}, 32'd1);
        chk("rst_async_rdy", {31'd0, Rdy_}, 32'd1);
        chk("rst_async_rd", RdData, 32'd0);
        chk("rst_async_irq", {30'd0, IrqRx, IrqTx}, 32'd0);
        @(negedge clk);
        CS_ = 1'b1; As_ = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd_reg("rst_status", 30'd0, 32'h0);
        rd_reg("rst_data", 30'd1, 32'h0);
        repeat (50) @(negedge clk);
        chk("rst_abort_tx", {31'd0, UartTX}, 32'd1);
        chk("rst_abort_irq", {31'd0, IrqTx}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
